tri_fetch: RTL and testbench



---
 rtl/gfx_pkg.sv | 20 ++
 rtl/tri_fetch_rd_valid_delay.sv | 27 ++
 rtl/tri_fetch.sv | 163 ++++++++++++++++
 tb/tb_tri_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types for the triangle front end: vertex/triangle bundles at the
// default geometry, the triangle index type and the fetch FSM state encoding.
package gfx_pkg;

  localparam int GFX_P_WIDTH = 16;
  localparam int GFX_NUM_TRI = 2048;

  typedef logic [2:0][GFX_P_WIDTH-1:0] vertex_t;
  typedef vertex_t [2:0]               triangle_t;
  typedef logic [$clog2(GFX_NUM_TRI)-1:0] tri_id_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tri_fetch_rd_valid_delay.sv
// LATENCY-stage 1-bit delay line that tracks which BRAM cycles return data.
// Asynchronous reset flushes any reads still in flight.
module rd_valid_delay #(
  parameter int LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [LATENCY-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[LATENCY-1];

endmodule

// File: rtl/tri_fetch.sv
// Triangle fetch: walks triangle IDs for a frame, reads three vertex words per
// triangle from a fixed-latency BRAM and presents each bundle on valid/ready.
module tri_fetch
  import gfx_pkg::*;
#(
  parameter int P_WIDTH     = GFX_P_WIDTH,
  parameter int NUM_TRI     = GFX_NUM_TRI,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_WIDTH  = $clog2(3*NUM_TRI)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic [$clog2(NUM_TRI):0]      tri_count_in,
  output logic [ADDR_WIDTH-1:0]         mem_addr_out,
  output logic                          mem_rd_en_out,
  input  logic [3*P_WIDTH-1:0]          mem_data_in,
  input  logic                          ready_in,
  output logic                          valid_out,
  output logic [$clog2(NUM_TRI)-1:0]    tri_id_out,
  output logic [2:0][2:0][P_WIDTH-1:0]  P_out,
  output logic                          last_tri_out,
  output logic                          busy_out,
  output logic                          frame_done_out
);

  localparam int TID_W = $clog2(NUM_TRI);
  localparam int CNT_W = TID_W + 1;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [TID_W-1:0]               tri_id_q, tri_id_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic                           rd_en_q, rd_en_d;
  logic [1:0]                     issue_q, issue_d;
  logic [1:0]                     cap_q, cap_d;
  logic [2:0][2:0][P_WIDTH-1:0]   p_q, p_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;
  logic                           done_q, done_d;
  logic                           rd_dly;

  rd_valid_delay #(
    .LATENCY(MEM_LATENCY)
  ) u_rd_delay (
    .clk_i(clk_in),
    .rst_i(rst_in),
    .d_i  (rd_en_q),
    .q_o  (rd_dly)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      tri_id_q <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      issue_q  <= '0;
      cap_q    <= '0;
      p_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tri_id_q <= tri_id_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      issue_q  <= issue_d;
      cap_q    <= cap_d;
      p_q      <= p_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tri_id_d = tri_id_q;
    addr_d   = addr_q;
    rd_en_d  = rd_en_q;
    issue_d  = issue_q;
    cap_d    = cap_q;
    p_d      = p_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;

    // Returning words may land while the last addresses are still being
    // issued (short latencies), so capture is independent of the FSM state.
    if (rd_dly) begin
      p_d[cap_q] = mem_data_in;
      cap_d      = (cap_q == 2'd2) ? 2'd0 : cap_q + 2'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          count_d  = (tri_count_in > CNT_W'(NUM_TRI)) ? CNT_W'(NUM_TRI) : tri_count_in;
          tri_id_d = '0;
          if (tri_count_in == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            addr_d  = '0;
            rd_en_d = 1'b1;
            issue_d = '0;
          end
        end
      end
      ST_FETCH: begin
        if (issue_q == 2'd2) begin
          rd_en_d = 1'b0;
          state_d = ST_WAIT;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          issue_d = issue_q + 2'd1;
        end
      end
      ST_WAIT: begin
        if (rd_dly && cap_q == 2'd2) begin
          valid_d = 1'b1;
          last_d  = ((CNT_W'(tri_id_q) + CNT_W'(1)) == count_q);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready_in) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            tri_id_d = tri_id_q + TID_W'(1);
            addr_d   = ADDR_WIDTH'((32'(tri_id_q) + 32'd1) * 32'd3);
            rd_en_d  = 1'b1;
            issue_d  = '0;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr_out   = addr_q;
  assign mem_rd_en_out  = rd_en_q;
  assign valid_out      = valid_q;
  assign tri_id_out     = tri_id_q;
  assign P_out          = p_q;
  assign last_tri_out   = last_q;
  assign busy_out       = (state_q != ST_IDLE);
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_tri_fetch.sv
// Scoreboard bench for tri_fetch: two instances (2048 tri / latency 2 and
// 4 tri / latency 1) against a BRAM model holding word n = {n+2, n+1, n}.
module tb_tri_fetch;

  localparam int PW  = 16;
  localparam int NA  = 2048;
  localparam int LA  = 2;
  localparam int NB  = 4;
  localparam int LB  = 1;
  localparam int AWA = $clog2(3*NA);
  localparam int AWB = $clog2(3*NB);
  localparam int TWA = $clog2(NA);
  localparam int TWB = $clog2(NB);

  typedef struct { int id; logic [9*PW-1:0] p; bit last; } exp_tri_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [3*PW-1:0] word(int n);
    return {PW'(n + 2), PW'(n + 1), PW'(n)};
  endfunction

  function automatic logic [9*PW-1:0] tri_p(int i);
    return {word(3*i + 2), word(3*i + 1), word(3*i)};
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic             a_start = 1'b0;
  logic [TWA:0]     a_count = '0;
  logic [AWA-1:0]   a_addr;
  logic             a_rd_en;
  logic [3*PW-1:0]  a_mem;
  logic             a_ready;
  logic             a_fix_rdy = 1'b0;
  logic             a_rnd_rdy = 1'b0;
  bit               a_rnd = 1'b0;
  logic             a_valid;
  logic [TWA-1:0]   a_id;
  logic [2:0][2:0][PW-1:0] a_p;
  logic             a_last, a_busy, a_done;
  assign a_ready = a_rnd ? a_rnd_rdy : a_fix_rdy;

  tri_fetch #(.P_WIDTH(PW), .NUM_TRI(NA), .MEM_LATENCY(LA)) dut_a (
    .clk_in(clk), .rst_in(rst), .start_in(a_start), .tri_count_in(a_count),
    .mem_addr_out(a_addr), .mem_rd_en_out(a_rd_en), .mem_data_in(a_mem),
    .ready_in(a_ready), .valid_out(a_valid), .tri_id_out(a_id), .P_out(a_p),
    .last_tri_out(a_last), .busy_out(a_busy), .frame_done_out(a_done)
  );

  // ---------------- instance B ----------------
  logic             b_start = 1'b0;
  logic [TWB:0]     b_count = '0;
  logic [AWB-1:0]   b_addr;
  logic             b_rd_en;
  logic [3*PW-1:0]  b_mem;
  logic             b_ready;
  logic             b_rnd_rdy = 1'b0;
  logic             b_valid;
  logic [TWB-1:0]   b_id;
  logic [2:0][2:0][PW-1:0] b_p;
  logic             b_last, b_busy, b_done;
  assign b_ready = b_rnd_rdy;

  tri_fetch #(.P_WIDTH(PW), .NUM_TRI(NB), .MEM_LATENCY(LB)) dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(b_start), .tri_count_in(b_count),
    .mem_addr_out(b_addr), .mem_rd_en_out(b_rd_en), .mem_data_in(b_mem),
    .ready_in(b_ready), .valid_out(b_valid), .tri_id_out(b_id), .P_out(b_p),
    .last_tri_out(b_last), .busy_out(b_busy), .frame_done_out(b_done)
  );

  // BRAM models: fixed latency, garbage whenever no read is due back
  logic [AWA-1:0]  a_pa [LA];
  logic            a_pe [LA];
  logic [AWB-1:0]  b_pa [LB];
  logic            b_pe [LB];
  logic [3*PW-1:0] junk;
  always @(posedge clk) begin
    a_pa[0] <= a_addr;
    a_pe[0] <= a_rd_en;
    b_pa[0] <= b_addr;
    b_pe[0] <= b_rd_en;
    junk    <= (3*PW)'({$urandom, $urandom});
    for (int i = 1; i < LA; i++) begin
      a_pa[i] <= a_pa[i-1];
      a_pe[i] <= a_pe[i-1];
    end
  end
  assign a_mem = (a_pe[LA-1] === 1'b1) ? word(int'(a_pa[LA-1])) : junk;
  assign b_mem = (b_pe[LB-1] === 1'b1) ? word(int'(b_pa[LB-1])) : junk;

  initial forever begin
    @(posedge clk);
    #1;
    a_rnd_rdy = 1'($urandom_range(0, 1));
    b_rnd_rdy = 1'($urandom_range(0, 1));
  end

  // ---------------- reference model state ----------------
  exp_tri_t qa[$];
  exp_tri_t qb[$];
  int qaddr_a[$];
  int qaddr_b[$];
  int a_done_cnt = 0, a_exp_done = 0;
  int b_done_cnt = 0, b_exp_done = 0;
  bit a_model_busy = 1'b0, b_model_busy = 1'b0;
  exp_tri_t ea, eb;

  // Monitors: every read strobe, handshake and frame_done is checked here
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (a_rd_en) begin
        if (qaddr_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_addr: unexpected read of %0d, no read required", a_addr);
        end else check("a_addr", a_addr, qaddr_a.pop_front());
      end
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_tri: unexpected triangle id %0d, none required", a_id);
        end else begin
          ea = qa.pop_front();
          check("a_tri_id", a_id, ea.id);
          check("a_tri_p", a_p, ea.p);
          check("a_tri_last", a_last, ea.last);
          $display("A tri id=%0d last=%0b", a_id, a_last);
        end
      end
      if (a_done) begin
        a_done_cnt++;
        a_model_busy = 1'b0;
        $display("A frame_done #%0d", a_done_cnt);
      end
      if (b_rd_en) begin
        if (qaddr_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_addr: unexpected read of %0d, no read required", b_addr);
        end else check("b_addr", b_addr, qaddr_b.pop_front());
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_tri: unexpected triangle id %0d, none required", b_id);
        end else begin
          eb = qb.pop_front();
          check("b_tri_id", b_id, eb.id);
          check("b_tri_p", b_p, eb.p);
          check("b_tri_last", b_last, eb.last);
          $display("B tri id=%0d last=%0b", b_id, b_last);
        end
      end
      if (b_done) begin
        b_done_cnt++;
        b_model_busy = 1'b0;
        $display("B frame_done #%0d", b_done_cnt);
      end
    end
  end

  task automatic start_a(int n);
    @(negedge clk);
    a_count = n[TWA:0];
    a_start = 1'b1;
    if (!a_model_busy) begin
      for (int i = 0; i < n; i++) qa.push_back('{i, tri_p(i), (i == n - 1)});
      for (int j = 0; j < 3*n; j++) qaddr_a.push_back(j);
      a_exp_done++;
      a_model_busy = 1'b1;
    end
    @(posedge clk);
    #1 a_start = 1'b0;
  endtask

  task automatic start_b(int n);
    @(negedge clk);
    b_count = n[TWB:0];
    b_start = 1'b1;
    if (!b_model_busy) begin
      for (int i = 0; i < n; i++) qb.push_back('{i, tri_p(i), (i == n - 1)});
      for (int j = 0; j < 3*n; j++) qaddr_b.push_back(j);
      b_exp_done++;
      b_model_busy = 1'b1;
    end
    @(posedge clk);
    #1 b_start = 1'b0;
  endtask

  task automatic wait_idle_a(string tag);
    for (int i = 0; i < 3000 && a_model_busy; i++) @(negedge clk);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_frames"}, a_done_cnt, a_exp_done);
  endtask

  task automatic wait_valid_a(string tag, output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (a_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_valid"}, a_valid, 1);
  endtask

  initial begin
    int lat;
    int done_edge;
    int done_hits;

    repeat (2) @(negedge clk);
    check("rst_valid", a_valid, 0);
    check("rst_last", a_last, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rd_en", a_rd_en, 0);
    check("rst_addr", a_addr, 0);
    check("rst_id", a_id, 0);
    check("rst_p", a_p, 0);
    check("rst_b_valid", b_valid, 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Two triangles, ready held high, latency from start
    a_fix_rdy = 1'b1;
    start_a(2);
    wait_valid_a("t1", lat);
    check("t1_latency", lat, LA + 3);
    check("t1_id0", a_id, 0);
    check("t1_p1", a_p[1], word(1));
    wait_idle_a("t1");

    // Downstream stall on triangle 0
    a_fix_rdy = 1'b0;
    start_a(3);
    wait_valid_a("t2", lat);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t2_hold_valid", a_valid, 1);
      check("t2_hold_id", a_id, qa[0].id);
      check("t2_hold_p", a_p, qa[0].p);
      check("t2_no_read", a_rd_en, 0);
    end
    @(posedge clk);
    #1 a_fix_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("t2_refetch_en", a_rd_en, 1);
    check("t2_refetch_addr", a_addr, 3);
    wait_idle_a("t2");

    // Empty frame: frame_done sampled by downstream on the second edge
    start_a(0);
    done_edge = 0;
    done_hits = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("t3_no_read", a_rd_en, 0);
      check("t3_no_valid", a_valid, 0);
      if (a_done) begin
        done_hits++;
        if (done_edge == 0) done_edge = i;
      end
    end
    check("t3_done_edge", done_edge, 2);
    check("t3_done_once", done_hits, 1);
    wait_idle_a("t3");

    // Start during HOLD is ignored
    a_fix_rdy = 1'b0;
    start_a(3);
    wait_valid_a("t4", lat);
    start_a(5);
    repeat (3) @(posedge clk);
    #1 a_fix_rdy = 1'b1;
    wait_idle_a("t4");
    check("t4_drained", qa.size(), 0);

    // Asynchronous reset while waiting on triangle 1 data
    start_a(3);
    wait_valid_a("t5", lat);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    qa.delete();
    qaddr_a.delete();
    if (a_model_busy) a_exp_done--;
    a_model_busy = 1'b0;
    #1;
    check("t5_valid", a_valid, 0);
    check("t5_busy", a_busy, 0);
    check("t5_rd_en", a_rd_en, 0);
    check("t5_addr", a_addr, 0);
    check("t5_id", a_id, 0);
    check("t5_p", a_p, 0);
    check("t5_last", a_last, 0);
    check("t5_done", a_done, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    a_rnd = 1'b1;
    start_a(2);
    wait_idle_a("t5");

    // Random frames with random backpressure
    for (int f = 0; f < 5; f++) begin
      start_a(int'($urandom_range(1, 7)));
      wait_idle_a("t6");
    end

    // Full-size frame on the small, latency-1 instance
    start_b(NB);
    for (int i = 0; i < 3000 && b_model_busy; i++) @(negedge clk);
    check("b_busy", b_busy, 0);
    check("b_frames", b_done_cnt, b_exp_done);
    start_b(2);
    for (int i = 0; i < 3000 && b_model_busy; i++) @(negedge clk);
    check("b_frames2", b_done_cnt, b_exp_done);

    check("a_tri_drained", qa.size(), 0);
    check("a_addr_drained", qaddr_a.size(), 0);
    check("b_tri_drained", qb.size(), 0);
    check("b_addr_drained", qaddr_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run still going at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
